led_pattern_sequencer: RTL and testbench

//  Controller for the 8-LED shift-register display. Owns the step-rate divider, the

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_pattern_sequencer_step_tick_gen.sv | 46 ++++
 rtl/led_pattern_sequencer.sv | 133 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_JOHNSON_R = 2'd0,
    MODE_JOHNSON_L = 2'd1,
    MODE_RUN       = 2'd2,
    MODE_BLINK     = 2'd3
  } mode_e;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_DIV_MAX  = 25_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE = 1_000_000;

  // Mode order on each accepted button press, wrapping back to the first mode.
  function automatic mode_e mode_next(input mode_e m);
    mode_e n;
    unique case (m)
      MODE_JOHNSON_R: n = MODE_JOHNSON_L;
      MODE_JOHNSON_L: n = MODE_RUN;
      MODE_RUN:       n = MODE_BLINK;
      MODE_BLINK:     n = MODE_JOHNSON_R;
      default:        n = MODE_JOHNSON_R;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_step_tick_gen.sv
// Step-rate divider: one tick every max(1, DIV_MAX >> speed) unpaused cycles.
module step_tick_gen #(
  parameter int unsigned DIV_MAX = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       restart,
  output logic       tick
);

  localparam int unsigned CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  logic [CW-1:0] r_cnt;
  logic [31:0]   w_lim;
  logic [31:0]   w_last;
  logic          w_at_end;

  // Limit follows speed every cycle; ">=" lets a shortened period fire at once.
  always_comb begin
    w_lim = 32'(DIV_MAX) >> speed;
    if (w_lim == 32'd0) begin
      w_lim = 32'd1;
    end
    w_last   = w_lim - 32'd1;
    w_at_end = (32'(r_cnt) >= w_last);
    tick     = w_at_end && !pause && !restart;
  end

  // Divider count: cleared by restart or at period end, frozen while paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (!pause) begin
      if (w_at_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// 8-LED pattern controller: button debounce, mode register, pattern register.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DIV_MAX  = DEFAULT_DIV_MAX,
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_btn,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode,
  output logic             step
);

  localparam int unsigned      DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [WIDTH-1:0] DOT = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [DBW-1:0]   r_db_cnt;
  logic             w_db_diff;
  logic             w_db_done;
  logic             w_mode_adv;
  logic             w_tick;
  mode_e            r_mode;
  mode_e            w_mode_nxt;
  logic [WIDTH-1:0] r_led;
  logic [WIDTH-1:0] w_led_nxt;
  logic             r_step;
  logic             w_step_nxt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mode_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level on the DEBOUNCE-th consecutive differing sample.
  always_comb begin
    w_db_diff  = (r_sync2 != r_stable);
    w_db_done  = w_db_diff && (r_db_cnt == DBW'(DEBOUNCE - 1));
    w_mode_adv = w_db_done && r_sync2;
  end

  // Debounce counter and stable level; any matching sample restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_cnt <= '0;
      r_stable <= 1'b0;
    end else begin
      if (!w_db_diff || w_db_done) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
      if (w_db_done) begin
        r_stable <= r_sync2;
      end
    end
  end

  step_tick_gen #(
    .DIV_MAX (DIV_MAX)
  ) u_step_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .speed   (speed),
    .pause   (pause),
    .restart (w_mode_adv),
    .tick    (w_tick)
  );

  // Mode state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode <= MODE_JOHNSON_R;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Next mode and next pattern; a mode change overrides a coincident tick.
  always_comb begin
    w_mode_nxt = r_mode;
    w_led_nxt  = r_led;
    w_step_nxt = 1'b0;
    if (w_mode_adv) begin
      w_mode_nxt = mode_next(r_mode);
      w_led_nxt  = (w_mode_nxt == MODE_RUN) ? DOT : '0;
    end else if (w_tick) begin
      w_step_nxt = 1'b1;
      unique case (r_mode)
        MODE_JOHNSON_R: w_led_nxt = {~r_led[0], r_led[WIDTH-1:1]};
        MODE_JOHNSON_L: w_led_nxt = {r_led[WIDTH-2:0], ~r_led[WIDTH-1]};
        MODE_RUN: begin
          if ($countones(r_led) != 1) begin
            w_led_nxt = DOT;
          end else begin
            w_led_nxt = {r_led[0], r_led[WIDTH-1:1]};
          end
        end
        MODE_BLINK:     w_led_nxt = ~r_led;
        default:        w_led_nxt = r_led;
      endcase
    end
  end

  // Pattern register and step pulse load together so step marks a fresh pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led  <= '0;
      r_step <= 1'b0;
    end else begin
      r_led  <= w_led_nxt;
      r_step <= w_step_nxt;
    end
  end

  assign led  = r_led;
  assign mode = r_mode;
  assign step = r_step;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with DIV_MAX=4, DEBOUNCE=3.
module tb_led_pattern_sequencer;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DIV_MAX  = 4;
  localparam int unsigned DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       pause = 1'b0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] jr_seq [16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                              8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  logic [7:0] jl_seq [3]  = '{8'h01, 8'h03, 8'h07};
  logic [7:0] run_seq [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] blk_seq [2] = '{8'hFF, 8'h00};

  led_pattern_sequencer #(
    .WIDTH    (WIDTH),
    .DIV_MAX  (DIV_MAX),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_btn (mode_btn),
    .speed    (speed),
    .pause    (pause),
    .led      (led),
    .mode     (mode),
    .step     (step)
  );

  always #5 clk = ~clk;

  // Reference model: mode, steps taken since the last mode entry, elapsed cycles.
  int   m_mode, m_phase, m_cnt, m_run;
  logic m_h0, m_h1, m_stable, m_step;

  function automatic logic [7:0] pattern(input int md, input int ph);
    int k;
    case (md)
      0: begin
        k = ph % 16;
        if (k <= 8) return 8'((16'hFF00 >> k) & 16'h00FF);
        return 8'(16'h00FF >> (k - 8));
      end
      1: begin
        k = ph % 16;
        if (k <= 8) return 8'((16'd1 << k) - 16'd1);
        return 8'((16'h00FF << (k - 8)) & 16'h00FF);
      end
      2: return 8'(16'h0080 >> (ph % 8));
      default: return ((ph % 2) == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic logic [10:0] exp_vec();
    return {pattern(m_mode, m_phase), 2'(m_mode), m_step};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cnt = 0; m_run = 0;
    m_h0 = 1'b0; m_h1 = 1'b0; m_stable = 1'b0; m_step = 1'b0;
  endtask

  task automatic model_update();
    logic samp;
    logic adv;
    int   lim;
    samp = m_h1;
    m_h1 = m_h0;
    m_h0 = mode_btn;
    adv  = 1'b0;
    if (samp != m_stable) begin
      m_run++;
      if (m_run == int'(DEBOUNCE)) begin
        m_stable = samp;
        m_run    = 0;
        adv      = samp;
      end
    end else begin
      m_run = 0;
    end
    m_step = 1'b0;
    if (adv) begin
      m_mode  = (m_mode + 1) % 4;
      m_phase = 0;
      m_cnt   = 0;
    end else if (!pause) begin
      lim = int'(DIV_MAX >> speed);
      if (lim < 1) lim = 1;
      if (m_cnt >= lim - 1) begin
        m_cnt  = 0;
        m_phase++;
        m_step = 1'b1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic press(input int len);
    mode_btn = 1'b1;
    repeat (len) advance();
    mode_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; speed = 2'd0; pause = 1'b0; mode_btn = 1'b0;
    model_reset();
    advance();
    advance();
    n_checks++;
    if (led !== 8'h00) $display("FAIL reset_led: got %h want 00", led); else n_pass++;
    n_checks++;
    if (mode !== 2'd0) $display("FAIL reset_mode: got %0d want 0", mode); else n_pass++;
    n_checks++;
    if (step !== 1'b0) $display("FAIL reset_step: got %b want 0", step); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_johnson_r();
    int idx = 0;
    int last = 0;
    for (int c = 1; c <= 72; c++) begin
      advance();
      n_checks++;
      if ({led, mode, step} !== exp_vec())
        $display("FAIL jr_cycle: got led=%h mode=%0d step=%b want %h", led, mode, step, exp_vec());
      else n_pass++;
      if (step === 1'b1) begin
        n_checks++;
        if (led !== jr_seq[idx % 16]) $display("FAIL jr_seq: got %h want %h", led, jr_seq[idx % 16]);
        else n_pass++;
        n_checks++;
        if (c - last != 4) $display("FAIL jr_spacing: got %0d want 4", c - last); else n_pass++;
        last = c;
        idx++;
      end
    end
    n_checks++;
    if (idx != 18) $display("FAIL jr_count: got %0d want 18", idx); else n_pass++;
  endtask

  task automatic test_speed();
    for (int s = 2; s <= 3; s++) begin
      speed = 2'(s);
      for (int c = 0; c < 8; c++) begin
        advance();
        n_checks++;
        if (step !== 1'b1 || {led, mode, step} !== exp_vec())
          $display("FAIL speed%0d_step: got led=%h step=%b want %h", s, led, step, exp_vec());
        else n_pass++;
      end
    end
    speed = 2'd0;
  endtask

  task automatic test_debounce();
    int got = 0;
    press(2);
    for (int c = 0; c < 8; c++) begin
      advance();
      n_checks++;
      if (mode !== 2'd0 || {led, mode, step} !== exp_vec())
        $display("FAIL db_short: got mode=%0d led=%h want mode 0 vec %h", mode, led, exp_vec());
      else n_pass++;
    end
    press(5);
    n_checks++;
    if (mode !== 2'd1 || led !== 8'h00 || step !== 1'b0)
      $display("FAIL db_accept: got mode=%0d led=%h step=%b want 1 00 0", mode, led, step);
    else n_pass++;
    for (int c = 0; c < 20 && got < 3; c++) begin
      advance();
      n_checks++;
      if (mode !== 2'd1 || {led, mode, step} !== exp_vec())
        $display("FAIL db_single: got mode=%0d led=%h want mode 1 vec %h", mode, led, exp_vec());
      else n_pass++;
      if (step === 1'b1) begin
        n_checks++;
        if (led !== jl_seq[got]) $display("FAIL jl_seq: got %h want %h", led, jl_seq[got]);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 3) $display("FAIL jl_timeout: got %0d steps want 3", got); else n_pass++;
  endtask

  task automatic test_modes();
    int got = 0;
    press(5);
    n_checks++;
    if (mode !== 2'd2 || led !== 8'h80 || step !== 1'b0)
      $display("FAIL run_seed: got mode=%0d led=%h step=%b want 2 80 0", mode, led, step);
    else n_pass++;
    for (int c = 0; c < 50 && got < 8; c++) begin
      advance();
      n_checks++;
      if ({led, mode, step} !== exp_vec())
        $display("FAIL run_cycle: got led=%h mode=%0d step=%b want %h", led, mode, step, exp_vec());
      else n_pass++;
      if (step === 1'b1) begin
        n_checks++;
        if (led !== run_seq[got]) $display("FAIL run_seq: got %h want %h", led, run_seq[got]);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 8) $display("FAIL run_timeout: got %0d steps want 8", got); else n_pass++;
    press(5);
    n_checks++;
    if (mode !== 2'd3 || led !== 8'h00 || step !== 1'b0)
      $display("FAIL blink_seed: got mode=%0d led=%h step=%b want 3 00 0", mode, led, step);
    else n_pass++;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      advance();
      if (step === 1'b1) begin
        n_checks++;
        if (led !== blk_seq[got]) $display("FAIL blink_seq: got %h want %h", led, blk_seq[got]);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 2) $display("FAIL blink_timeout: got %0d steps want 2", got); else n_pass++;
    press(5);
    n_checks++;
    if (mode !== 2'd0 || led !== 8'h00 || step !== 1'b0)
      $display("FAIL wrap_seed: got mode=%0d led=%h step=%b want 0 00 0", mode, led, step);
    else n_pass++;
  endtask

  task automatic test_pause();
    int k;
    logic [7:0] hold;
    k = 0;
    while (step !== 1'b1 && k < 10) begin
      advance();
      k++;
    end
    n_checks++;
    if (step !== 1'b1) $display("FAIL pause_sync: got step=%b want 1", step); else n_pass++;
    advance();
    advance();
    pause = 1'b1;
    hold  = pattern(m_mode, m_phase);
    for (int c = 0; c < 10; c++) begin
      advance();
      n_checks++;
      if (step !== 1'b0 || led !== hold)
        $display("FAIL pause_hold: got led=%h step=%b want %h 0", led, step, hold);
      else n_pass++;
    end
    pause = 1'b0;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      advance();
      if (step === 1'b1) begin
        k = c;
        break;
      end
    end
    n_checks++;
    if (k != 2) $display("FAIL pause_resume: got step after %0d cycles want 2", k); else n_pass++;
  endtask

  task automatic test_back_to_back();
    speed = 2'd2;
    repeat (6) advance();
    press(5);
    n_checks++;
    if (mode !== 2'd1 || led !== 8'h00 || step !== 1'b0)
      $display("FAIL collide_jl: got mode=%0d led=%h step=%b want 1 00 0", mode, led, step);
    else n_pass++;
    repeat (6) advance();
    press(5);
    n_checks++;
    if (mode !== 2'd2 || led !== 8'h80 || step !== 1'b0)
      $display("FAIL collide_run: got mode=%0d led=%h step=%b want 2 80 0", mode, led, step);
    else n_pass++;
    advance();
    n_checks++;
    if (led !== 8'h40 || step !== 1'b1)
      $display("FAIL collide_next: got led=%h step=%b want 40 1", led, step);
    else n_pass++;
    speed = 2'd0;
  endtask

  task automatic test_async_reset();
    repeat (3) advance();
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (led !== 8'h00 || mode !== 2'd0 || step !== 1'b0)
      $display("FAIL async_reset: got led=%h mode=%0d step=%b want 00 0 0", led, mode, step);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int btn_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 9) < 2);
      if (btn_left == 0) begin
        mode_btn = 1'($urandom_range(0, 1));
        btn_left = int'($urandom_range(1, 8));
      end
      btn_left--;
      advance();
      n_checks++;
      if ({led, mode, step} !== exp_vec())
        $display("FAIL random_cycle%0d: got led=%h mode=%0d step=%b want %h", c, led, mode, step, exp_vec());
      else n_pass++;
    end
    pause = 1'b0;
    mode_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_johnson_r();
    test_speed();
    test_debounce();
    test_modes();
    test_pause();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
